alu_request_arbiter: RTL and testbench

//   Shares the single 64-bit arithmetic_logic_unit between NUM_REQ requesters (e.g. execute, branch/AGU).

---
 rtl/alu_request_arbiter_pkg.sv | 34 +++
 rtl/alu_request_arbiter_if.sv | 35 +++
 rtl/alu_request_arbiter_rr_arbiter.sv | 34 +++
 rtl/alu_request_arbiter.sv | 122 ++++++++++++
 tb/tb_alu_request_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_request_arbiter_pkg.sv
// Shared types and constants for the ALU request arbiter.
//   AluXlen / AluFuncW : default operand width and ALU function-code width
//   alu_func_t         : ALU function codes (SLT is code 0)
//   alu_flags_t        : comparison flags {le, lt, ne, eq} as produced by the ALU
//   arb_state_t        : arbiter FSM states
package alu_request_arbiter_pkg;

    localparam int unsigned AluXlen  = 64;
    localparam int unsigned AluFuncW = 4;

    typedef enum logic [AluFuncW-1:0] {
        FnSlt  = 4'd0,
        FnAdd  = 4'd1,
        FnSub  = 4'd2,
        FnAnd  = 4'd3,
        FnOr   = 4'd4,
        FnXor  = 4'd5,
        FnSltu = 4'd6
    } alu_func_t;

    typedef struct packed {
        logic le;
        logic lt;
        logic ne;
        logic eq;
    } alu_flags_t;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } arb_state_t;

endpackage

// File: rtl/alu_request_arbiter_if.sv
// Requester-side bundle of the ALU request arbiter.
//   req_valid/req_ready      : per-requester request handshake (ready is a one-hot grant)
//   req_func/data_0/data_1   : flattened per-requester payloads, requester i at slice i
//   rsp_valid/rsp_ready      : per-requester response handshake (valid is one-hot)
//   rsp_data/rsp_flags       : shared result bus, meaningful where rsp_valid is set
// master = the requesters, slave = the arbiter.
interface alu_request_arbiter_if
    import alu_request_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned XLEN    = AluXlen,
    parameter int unsigned FUNC_W  = AluFuncW
) ();

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*FUNC_W-1:0] req_func;
    logic [NUM_REQ*XLEN-1:0]   req_data_0;
    logic [NUM_REQ*XLEN-1:0]   req_data_1;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [XLEN-1:0]           rsp_data;
    alu_flags_t                rsp_flags;

    modport master (
        output req_valid, req_func, req_data_0, req_data_1, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_flags
    );

    modport slave (
        input  req_valid, req_func, req_data_0, req_data_1, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_flags
    );

endinterface

// File: rtl/alu_request_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : index of the previous winner (it gets lowest priority)
//   gnt : one-hot grant, zero when no request
//   idx : binary index of the granted requester
module alu_request_arbiter_rr_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] idx
);

    always_comb begin
        logic            found;
        logic [IdxW-1:0] cand;
        found = 1'b0;
        cand  = '0;
        gnt   = '0;
        idx   = '0;
        // Search starts one past the last winner and wraps, so ptr itself is checked last.
        for (int unsigned off = 1; off <= N; off++) begin
            cand = IdxW'((32'(ptr) + off) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/alu_request_arbiter.sv
// Shares one ALU between NUM_REQ requesters, one operation in flight.
//   clk, rst   : clock, asynchronous active-low reset
//   bus        : requester handshake/payload bundle (slave side)
//   alu_func   : function code to the ALU
//   alu_data_0 : operand A to the ALU
//   alu_data_1 : operand B to the ALU
//   alu_data_2 : combinational ALU result
//   alu_flags  : combinational ALU flags {le, lt, ne, eq}
// Flow: IDLE grants round-robin and latches the winner's operands, EXEC gives the ALU one
// cycle and captures its outputs, RESP holds the result for the winner until it takes it.
module alu_request_arbiter
    import alu_request_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned XLEN    = AluXlen,
    parameter int unsigned FUNC_W  = AluFuncW
) (
    input  logic                clk,
    input  logic                rst,
    alu_request_arbiter_if.slave bus,
    output logic [FUNC_W-1:0]   alu_func,
    output logic [XLEN-1:0]     alu_data_0,
    output logic [XLEN-1:0]     alu_data_1,
    input  logic [XLEN-1:0]     alu_data_2,
    input  alu_flags_t          alu_flags
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t        state_q, state_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [FUNC_W-1:0] func_q, func_d;
    logic [XLEN-1:0]   data0_q, data0_d;
    logic [XLEN-1:0]   data1_q, data1_d;
    logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
    alu_flags_t        rsp_flags_q, rsp_flags_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IdxW-1:0]    gnt_idx;

    alu_request_arbiter_rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .req (bus.req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        idx_d         = idx_q;
        func_d        = func_q;
        data0_d       = data0_q;
        data1_d       = data1_q;
        rsp_data_d    = rsp_data_q;
        rsp_flags_d   = rsp_flags_q;
        bus.req_ready = '0;
        bus.rsp_valid = '0;

        case (state_q)
            StIdle: begin
                // The grant is a subset of req_valid, so any grant bit is an accept.
                bus.req_ready = gnt;
                if (|gnt) begin
                    func_d  = bus.req_func[gnt_idx*FUNC_W +: FUNC_W];
                    data0_d = bus.req_data_0[gnt_idx*XLEN +: XLEN];
                    data1_d = bus.req_data_1[gnt_idx*XLEN +: XLEN];
                    idx_d   = gnt_idx;
                    ptr_d   = gnt_idx;
                    state_d = StExec;
                end
            end
            StExec: begin
                rsp_data_d  = alu_data_2;
                rsp_flags_d = alu_flags;
                state_d     = StResp;
            end
            StResp: begin
                bus.rsp_valid[idx_q] = 1'b1;
                if (bus.rsp_ready[idx_q]) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            // Previous winner = last requester, so requester 0 wins first.
            ptr_q       <= IdxW'(NUM_REQ - 1);
            idx_q       <= '0;
            func_q      <= '0;
            data0_q     <= '0;
            data1_q     <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            func_q      <= func_d;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    assign alu_func      = func_q;
    assign alu_data_0    = data0_q;
    assign alu_data_1    = data1_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_flags = rsp_flags_q;

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Bench for alu_request_arbiter: directed requests, expected responses queued at issue time,
// a forked monitor pops and compares on every response handshake.
module tb_alu_request_arbiter;
    import alu_request_arbiter_pkg::*;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned XLEN    = 64;
    localparam int unsigned FUNC_W  = 4;

    logic              clk;
    logic              rst;
    logic [FUNC_W-1:0] alu_func;
    logic [XLEN-1:0]   alu_data_0;
    logic [XLEN-1:0]   alu_data_1;
    logic [XLEN-1:0]   alu_data_2;
    alu_flags_t        alu_flags;

    alu_request_arbiter_if #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .FUNC_W(FUNC_W)) bus ();

    alu_request_arbiter #(
        .NUM_REQ (NUM_REQ),
        .XLEN    (XLEN),
        .FUNC_W  (FUNC_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_func   (alu_func),
        .alu_data_0 (alu_data_0),
        .alu_data_1 (alu_data_1),
        .alu_data_2 (alu_data_2),
        .alu_flags  (alu_flags)
    );

    // ALU stub
    always_comb begin
        alu_data_2 = '0;
        case (alu_func)
            FnSlt:   alu_data_2 = 64'($signed(alu_data_0) < $signed(alu_data_1));
            FnAdd:   alu_data_2 = alu_data_0 + alu_data_1;
            FnSub:   alu_data_2 = alu_data_0 - alu_data_1;
            FnAnd:   alu_data_2 = alu_data_0 & alu_data_1;
            FnOr:    alu_data_2 = alu_data_0 | alu_data_1;
            FnXor:   alu_data_2 = alu_data_0 ^ alu_data_1;
            FnSltu:  alu_data_2 = 64'(alu_data_0 < alu_data_1);
            default: alu_data_2 = '0;
        endcase
        alu_flags.eq = (alu_data_0 == alu_data_1);
        alu_flags.ne = (alu_data_0 != alu_data_1);
        alu_flags.lt = ($signed(alu_data_0) < $signed(alu_data_1));
        alu_flags.le = ($signed(alu_data_0) <= $signed(alu_data_1));
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1);
    end

    typedef struct {
        int          owner;
        logic [63:0] data;
        logic [3:0]  flags;
    } exp_t;

    exp_t               exp_q[$];
    int                 n_pass;
    int                 n_total;
    logic [NUM_REQ-1:0] acc_mon;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic monitor();
        logic [NUM_REQ-1:0]        prev_rsp  = '0;
        logic [NUM_REQ-1:0]        prev_pend = '0;
        logic [NUM_REQ*FUNC_W-1:0] prev_func = '0;
        logic [NUM_REQ*XLEN-1:0]   prev_d0   = '0;
        logic [NUM_REQ*XLEN-1:0]   prev_d1   = '0;
        int   cyc    = 0;
        int   acc_cyc = -100;
        int   owner;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            acc_mon = bus.req_valid & bus.req_ready;
            if (!rst) begin
                prev_rsp  = '0;
                prev_pend = '0;
                acc_cyc   = -100;
                continue;
            end
            // Requesters must hold valid and payload until accepted.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (prev_pend[i]) begin
                    assert (bus.req_valid[i]
                            && bus.req_func[i*FUNC_W +: FUNC_W] == prev_func[i*FUNC_W +: FUNC_W]
                            && bus.req_data_0[i*XLEN +: XLEN] == prev_d0[i*XLEN +: XLEN]
                            && bus.req_data_1[i*XLEN +: XLEN] == prev_d1[i*XLEN +: XLEN])
                    else $error("stimulus changed request %0d before acceptance", i);
                end
            end
            prev_pend = bus.req_valid & ~bus.req_ready;
            prev_func = bus.req_func;
            prev_d0   = bus.req_data_0;
            prev_d1   = bus.req_data_1;

            if (|acc_mon) begin
                check("grant_onehot", 64'($countones(bus.req_ready)), 64'd1);
                acc_cyc = cyc;
            end
            if (|bus.rsp_valid && prev_rsp == '0) begin
                check("rsp_latency", 64'(cyc - acc_cyc), 64'd2);
            end
            if (|(bus.rsp_valid & bus.rsp_ready)) begin
                check("rsp_onehot", 64'($countones(bus.rsp_valid)), 64'd1);
                owner = -1;
                for (int i = 0; i < NUM_REQ; i++) if (bus.rsp_valid[i]) owner = i;
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_rsp: got response for %0d, required none", owner);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_owner", 64'(owner), 64'(e.owner));
                    check("rsp_data", bus.rsp_data, e.data);
                    check("rsp_flags", 64'(bus.rsp_flags), 64'(e.flags));
                end
            end
            prev_rsp = bus.rsp_valid;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.req_valid = bus.req_valid & ~acc_mon;
    endtask

    task automatic post(input int r, input logic [3:0] f, input logic [63:0] a,
                        input logic [63:0] b);
        bus.req_valid[r]               = 1'b1;
        bus.req_func[r*FUNC_W +: FUNC_W] = f;
        bus.req_data_0[r*XLEN +: XLEN] = a;
        bus.req_data_1[r*XLEN +: XLEN] = b;
    endtask

    task automatic expect_rsp(input int owner, input logic [63:0] data, input logic [3:0] flags);
        exp_t e;
        e.owner = owner;
        e.data  = data;
        e.flags = flags;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.req_valid != '0) && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0 || bus.req_valid != '0) begin
            n_total++;
            $display("FAIL %s_drain: %0d responses still pending, required 0", name, exp_q.size());
            exp_q.delete();
            bus.req_valid = '0;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_req_ready"}, 64'(bus.req_ready), 64'd0);
        check({name, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        check({name, "_rsp_data"}, bus.rsp_data, 64'd0);
        check({name, "_rsp_flags"}, 64'(bus.rsp_flags), 64'd0);
        check({name, "_alu_func"}, 64'(alu_func), 64'd0);
        check({name, "_alu_data_0"}, alu_data_0, 64'd0);
        check({name, "_alu_data_1"}, alu_data_1, 64'd0);
    endtask

    task automatic do_reset(input string name);
        bus.req_valid = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs(name);
        rst = 1'b1;
    endtask

    initial begin
        int n;
        n_pass         = 0;
        n_total        = 0;
        acc_mon        = '0;
        rst            = 1'b0;
        bus.req_valid  = '0;
        bus.req_func   = '0;
        bus.req_data_0 = '0;
        bus.req_data_1 = '0;
        bus.rsp_ready  = '1;
        fork
            monitor();
        join_none

        do_reset("reset0");

        // SLT -1 < 1 from requester 0, which wins first out of reset.
        post(0, FnSlt, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        expect_rsp(0, 64'd1, 4'b1110);
        #1;
        check("first_grant", 64'(bus.req_ready), 64'd1);
        drain("slt", 50);

        // Contention: requester 0 won last, so requester 1 leads each round.
        for (int k = 0; k < 3; k++) begin
            post(0, FnAdd, 64'(10 + k), 64'd3);
            post(1, FnSub, 64'(k), 64'd5);
            expect_rsp(1, 64'(k) - 64'd5, 4'b1110);
            expect_rsp(0, 64'(13 + k), 4'b0010);
            drain("contend", 50);
        end

        // Owner stalls its response; a non-owner ready and a new request must not matter.
        bus.rsp_ready = 2'b10;
        post(0, FnOr, 64'h1234_0000, 64'h0000_5678);
        expect_rsp(0, 64'h1234_5678, 4'b0010);
        n = 0;
        while (!bus.rsp_valid[0] && n < 20) begin
            tick();
            n++;
        end
        check("stall_rsp_seen", 64'(bus.rsp_valid[0]), 64'd1);
        post(1, FnAnd, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFF);
        expect_rsp(1, 64'hFF, 4'b1110);
        for (int s = 0; s < 5; s++) begin
            #1;
            check("stall_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check("stall_rsp_data", bus.rsp_data, 64'h1234_5678);
            check("stall_rsp_flags", 64'(bus.rsp_flags), 64'b0010);
            check("stall_req_ready", 64'(bus.req_ready), 64'd0);
            tick();
        end
        bus.rsp_ready = 2'b11;
        drain("stall", 50);

        // Only requester 1 after reset; then contention favours requester 0.
        do_reset("reset1");
        post(1, FnXor, 64'hAAAA, 64'h5555);
        expect_rsp(1, 64'hFFFF, 4'b0010);
        #1;
        check("req1_grant", 64'(bus.req_ready), 64'd2);
        drain("req1_only", 50);
        post(0, FnSltu, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        post(1, FnSlt, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        expect_rsp(0, 64'd1, 4'b0010);
        expect_rsp(1, 64'd0, 4'b0010);
        drain("after_req1", 50);

        // Reset while the op is in EXEC: no response, then a retry completes.
        post(0, FnSub, 64'd7, 64'd2);
        n = 0;
        while (bus.req_valid[0] && n < 10) begin
            tick();
            n++;
        end
        check("exec_operand", alu_data_0, 64'd7);
        rst = 1'b0;
        #1;
        check_reset_outputs("reset_exec");
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_hold_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        end
        rst = 1'b1;
        tick();
        post(0, FnSub, 64'd7, 64'd2);
        expect_rsp(0, 64'd5, 4'b0010);
        drain("retry", 50);

        // Equal operands from requester 1: eq and le set, delivered to port 1 only.
        post(1, FnSub, 64'd5, 64'd5);
        expect_rsp(1, 64'd0, 4'b1001);
        drain("equal", 50);
        repeat (2) tick();
        check("idle_hold_func", 64'(alu_func), 64'(FnSub));
        check("idle_hold_data_0", alu_data_0, 64'd5);
        check("idle_hold_data_1", alu_data_1, 64'd5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
